// File: rtl/adder_issue_collect.sv
// adder_issue_collect: issues operand pairs into a fixed-latency adder and collects results in order
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_a/in_b operands
//   adder_a/adder_b       combinational copies of in_a/in_b to the adder
//   adder_sum/adder_ovf   adder result, meaningful LATENCY edges after the operands
//   out_valid/out_ready   result handshake; out_sum/out_ovf head of the result FIFO
//   ovf_count             saturating count of delivered results with out_ovf=1
//   busy                  any operation in flight or queued
module adder_issue_collect #(
  parameter int WIDTH   = 25,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [WIDTH:0] mem_q [DEPTH];
  logic [CW:0] credits;
  logic acc, wr, pop;
  assign adder_a = in_a;
  assign adder_b = in_b;
  // Every op in flight already owns a FIFO slot, so a write can never find the FIFO full.
  always_comb begin
    credits = {1'b0, cnt_q};
    for (int i = 0; i < LATENCY; i++) credits = credits + (CW+1)'(vld_q[i]);
  end
  assign in_ready  = credits < (CW+1)'(DEPTH);
  assign acc       = in_valid & in_ready;
  assign wr        = vld_q[LATENCY-1];
  assign out_valid = cnt_q != '0;
  assign pop       = out_valid & out_ready;
  assign {out_ovf, out_sum} = mem_q[rp_q];
  assign ovf_count = ovf_cnt_q;
  assign busy      = (|vld_q) | out_valid;
  always_comb begin
    vld_d     = LATENCY'({vld_q, acc});
    wp_d      = wp_q + AW'(wr);
    rp_d      = rp_q + AW'(pop);
    cnt_d     = cnt_q + CW'(wr) - CW'(pop);
    ovf_cnt_d = (pop && out_ovf && !(&ovf_cnt_q)) ? ovf_cnt_q + CNT_W'(1) : ovf_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      ovf_cnt_q <= '0;
    end else begin
      vld_q     <= vld_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= {adder_ovf, adder_sum};
  end
  a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr && cnt_q == CW'(DEPTH)));
endmodule

// File: tb/tb_adder_issue_collect.sv
// tb_adder_issue_collect: directed and random stimulus checked against a queue-based result model
module tb_adder_issue_collect;
  localparam int W = 25;
  localparam int D = 4;
  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_ovf, busy;
  logic [W-1:0] adder_a, adder_b, out_sum;
  logic [15:0] ovf_count;
  logic [W-1:0] a1, b1, sum_q;
  logic ovf_q;
  int asserts = 0, fails = 0;
  typedef struct {
    logic [W-1:0] s;
    logic o;
    int rdy;
  } res_t;
  res_t q[$];
  int cyc = 0;
  int m_ovf = 0;
  always #5 clk = ~clk;
  adder_issue_collect dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .adder_a(adder_a), .adder_b(adder_b),
    .adder_sum(sum_q), .adder_ovf(ovf_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .ovf_count(ovf_count), .busy(busy)
  );
  // two-stage registered adder, carry-out as overflow
  always_ff @(posedge clk) begin
    a1 <= adder_a;
    b1 <= adder_b;
    {ovf_q, sum_q} <= {1'b0, a1} + {1'b0, b1};
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit m_valid();
    return q.size() > 0 && q[0].rdy <= cyc;
  endfunction
  // model: an accepted op becomes visible two edges later; outstanding ops never exceed D
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_ovf = 0;
    end else begin
      automatic bit p = m_valid() && out_ready;
      automatic bit a = in_valid && q.size() < D;
      automatic logic [W:0] t = {1'b0, in_a} + {1'b0, in_b};
      if (p) begin
        if (q[0].o && m_ovf < 65535) m_ovf++;
        void'(q.pop_front());
      end
      cyc++;
      if (a) q.push_back('{t[W-1:0], t[W], cyc + 2});
    end
  end
  initial forever begin
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(q.size() < D));
    chk("out_valid", 32'(out_valid), 32'(m_valid()));
    if (m_valid()) begin
      chk("out_sum", 32'(out_sum), 32'(q[0].s));
      chk("out_ovf", 32'(out_ovf), 32'(q[0].o));
    end
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain(string nm);
    int n = 0;
    out_ready = 1;
    in_valid = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk(nm, 32'(busy), 0);
  endtask
  task automatic single(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] es, logic eo, string nm);
    in_a = a;
    in_b = b;
    in_valid = 1;
    out_ready = 1;
    chk({nm, "_ready"}, 32'(in_ready), 1);
    tick();
    in_valid = 0;
    chk({nm, "_e0"}, 32'(out_valid), 0);
    tick();
    chk({nm, "_e1"}, 32'(out_valid), 0);
    tick();
    chk({nm, "_e2"}, 32'(out_valid), 1);
    chk({nm, "_sum"}, 32'(out_sum), 32'(es));
    chk({nm, "_ovf"}, 32'(out_ovf), 32'(eo));
  endtask
  initial begin
    int k, stalls, nres;
    bit r;
    logic [W-1:0] got;
    #1 rst_n = 0;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf_count", 32'(ovf_count), 0);
    single(25'h0000005, 25'h0000003, 25'h0000008, 1'b0, "single");
    tick();
    chk("single_cnt", 32'(ovf_count), 0);
    single(25'h1FFFFFF, 25'h0000001, 25'h0000000, 1'b1, "carry");
    chk("carry_cnt_before", 32'(ovf_count), 0);
    tick();
    chk("carry_cnt_after", 32'(ovf_count), 1);
    out_ready = 0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      in_a = W'(k * 32'h111111 + 1);
      in_b = W'(k + 2);
      in_valid = 1;
      r = in_ready;
      tick();
      if (r) k++;
    end
    chk("bp_accepted", 32'(k), 4);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_head", 32'(out_sum), 3);
    out_ready = 1;
    for (int c = 0; c < 200 && k < 10; c++) begin
      in_a = W'(k * 32'h111111 + 1);
      in_b = W'(k + 2);
      in_valid = 1;
      r = in_ready;
      tick();
      if (r) k++;
    end
    chk("bp_all_accepted", 32'(k), 10);
    drain("bp_drain");
    stalls = 0;
    for (int c = 0; c < 100; c++) begin
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_valid = 1;
      if (!in_ready) stalls++;
      tick();
    end
    chk("stream_stalls", 32'(stalls), 0);
    drain("stream_drain");
    for (int c = 0; c < 1000; c++) begin
      in_a = W'($urandom);
      in_b = ($urandom_range(0, 3) == 0) ? 25'h1FFFFFF : W'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain("rand_drain");
    chk("rand_ovf_seen", 32'(ovf_count > 1), 1);
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      in_a = (c == 0) ? 25'h1FFFFFF : W'(c);
      in_b = 25'h0000001;
      in_valid = 1;
      tick();
    end
    in_valid = 0;
    tick();
    rst_n = 0;
    #2;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ovf_count", 32'(ovf_count), 0);
    out_ready = 1;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1;
    tick();
    in_a = 25'h0000007;
    in_b = 25'h0000009;
    in_valid = 1;
    tick();
    in_valid = 0;
    nres = 0;
    got = '0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        nres++;
        got = out_sum;
      end
      tick();
    end
    chk("midrst_nres", 32'(nres), 1);
    chk("midrst_sum", 32'(got), 32'h10);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/adder_issue_collect.md
Name: adder_issue_collect

Overview:
- Client-side controller for the 25-bit registered adder top (`adder_top`: 2-cycle latency, no handshake).
- Accepts operand pairs on a valid/ready interface and drives them into the adder.
- Tracks each operation's flight through the adder's fixed latency, captures `sum`/`overflow` into a small result FIFO, and presents results on a valid/ready output.
- Keeps a saturating overflow event counter. Sits between the operand source and the adder, and between the adder and the result consumer.

Parameters:
- WIDTH, 25, operand/sum width; must match the adder.
- LATENCY, 2, clock edges from operands presented on `adder_a`/`adder_b` to a valid `adder_sum`.
- DEPTH, 4, result FIFO entries; power of two, ≥ LATENCY.
- CNT_W, 16, overflow counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- adder_a  output  WIDTH  to adder A; combinational pass-through of in_a.
- adder_b  output  WIDTH  to adder B; combinational pass-through of in_b.
- adder_sum  input  WIDTH  from adder sum.
- adder_ovf  input  1  from adder overflow.
- out_valid  output  1  result available at FIFO head.
- out_ready  input  1  consumer takes result.
- out_sum  output  WIDTH  head-entry sum.
- out_ovf  output  1  head-entry overflow flag.
- ovf_count  output  CNT_W  number of delivered results with ovf=1; saturating.
- busy  output  1  at least one operation in flight or in the FIFO.

Behaviour:
- Reset (rst_n low, asynchronous):
  - In-flight shift register cleared; FIFO pointers and count set to 0.
  - ovf_count=0, out_valid=0, busy=0, in_ready=1 after release.
  - Asserting reset mid-operation discards all in-flight and queued results. No result from pre-reset operands may ever appear at the output.
- Accept: acc = in_valid & in_ready.
  - adder_a/adder_b always follow in_a/in_b. The adder samples them every edge.
  - Only accepted cycles are tracked; results from non-accepted cycles are ignored.
- Flight tracking:
  - Shift register vld[LATENCY-1:0]. Each edge: vld[0] <= acc, vld[i] <= vld[i-1].
  - When vld[LATENCY-1]=1 in a cycle, adder_sum/adder_ovf hold that operation's result. They are written to the FIFO at the end of that cycle.
  - Total latency from accept edge E to out_valid rising is E+LATENCY edges, when the FIFO is empty.
- Credit flow control:
  - in_ready = (fifo_count + popcount(vld)) < DEPTH, combinational from registered state only (no path from in_valid or out_ready).
  - This guarantees a FIFO write never finds the FIFO full. A write attempt while full is a design error; flag it with an assertion in simulation.
- FIFO:
  - First-word fall-through. out_valid = fifo_count != 0.
  - pop = out_valid & out_ready. Simultaneous write and pop in the same cycle keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
  - out_sum/out_ovf are stable while out_valid=1 and out_ready=0.
- ovf_count: increments on a pop whose out_ovf=1, saturating at all-ones; never wraps.
- busy = |vld | (fifo_count != 0).
- Throughput: 1 operation/cycle sustained when out_ready is held at 1.
- Order: results are delivered strictly in accept order.

Test Plan:
- Reset then single op: in_a=0x0000005, in_b=0x0000003, out_ready=1 → out_valid high exactly 2 edges after the accept edge; out_sum=0x0000008, out_ovf=0, ovf_count stays 0.
- Carry/overflow: in_a=0x1FFFFFF, in_b=0x0000001 → out_sum=0x0000000, out_ovf=1; ovf_count=1 after the pop.
- Backpressure: out_ready=0 and in_valid=1 continuously with 10 distinct pairs → exactly 4 accepted; in_ready drops after the 4th accept; out_sum stable. Raising out_ready → the 4 results in order, followed by the remaining 6 results in order; no loss or duplication.
- Streaming: 100 random back-to-back pairs with out_ready=1 → one result per cycle after the initial 2-cycle latency; all sums match the model.
- Gaps and simultaneity: toggle in_valid and out_ready randomly over 1000 cycles → FIFO never overflows; results stay in order; a simultaneous write+pop leaves the count unchanged.
- Reset mid-flight: accept 3 ops, assert rst_n low one cycle later → out_valid=0, busy=0, ovf_count=0. After release, a new op 7+9 yields exactly one result 0x0000010.
